// File: rtl/poly_add_ctrl.sv
// poly_add_ctrl: streams A[i]+B[i] pairs through an external modular adder into a
// destination memory; write-back is paced purely by the adder's valid, not a fixed delay.
module poly_add_ctrl #(
    parameter int N  = 256,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    input  logic [11:0]   a_rdata_i,
    input  logic [11:0]   b_rdata_i,
    output logic [11:0]   add_op1_o,
    output logic [11:0]   add_op2_o,
    output logic          add_valid_o,
    input  logic [11:0]   add_result_i,
    input  logic          add_valid_i,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [11:0]   wr_data_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t        r_state;
    logic [AW-1:0] r_rd_cnt;
    logic [AW-1:0] r_wr_cnt;
    logic          r_add_valid;
    logic          w_busy;
    logic          w_wr;
    logic          w_rd_last;
    logic          w_wr_last;
    assign w_busy    = (r_state == ISSUE) || (r_state == DRAIN);
    assign w_wr      = add_valid_i && w_busy;
    assign w_rd_last = r_rd_cnt == AW'(N - 1);
    assign w_wr_last = r_wr_cnt == AW'(N - 1);
    // Counters saturate at N-1 so a stray adder valid can never wrap into address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_add_valid <= 1'b0;
        end else begin
            r_add_valid <= r_state == ISSUE;
            if (w_wr && !w_wr_last) r_wr_cnt <= r_wr_cnt + 1'b1;
            case (r_state)
                IDLE: if (start_i) begin
                    r_state  <= ISSUE;
                    r_rd_cnt <= '0;
                    r_wr_cnt <= '0;
                end
                ISSUE: begin
                    if (!w_rd_last) r_rd_cnt <= r_rd_cnt + 1'b1;
                    if (w_wr && w_wr_last) r_state <= DONE;
                    else if (w_rd_last) r_state <= DRAIN;
                end
                DRAIN: if (w_wr && w_wr_last) r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign busy_o      = w_busy;
    assign done_o      = r_state == DONE;
    assign rd_en_o     = r_state == ISSUE;
    assign rd_addr_o   = rd_en_o ? r_rd_cnt : '0;
    assign add_valid_o = r_add_valid;
    assign add_op1_o   = r_add_valid ? a_rdata_i : '0;
    assign add_op2_o   = r_add_valid ? b_rdata_i : '0;
    assign wr_en_o     = w_wr;
    assign wr_addr_o   = w_wr ? r_wr_cnt : '0;
    assign wr_data_o   = w_wr ? add_result_i : '0;
endmodule

// File: tb/tb_poly_add_ctrl.sv
// tb_poly_add_ctrl: directed bench with source memories, a variable-latency modular adder
// model and a write monitor feeding immediate-assertion checks.
module tb_poly_add_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        busy_o, done_o, rd_en_o, wr_en_o, add_valid_o, add_valid_i;
    logic [7:0]  rd_addr_o, wr_addr_o;
    logic [11:0] a_rdata_i, b_rdata_i, add_op1_o, add_op2_o, add_result_i, wr_data_o;

    poly_add_ctrl #(.N(256), .AW(8)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .a_rdata_i(a_rdata_i), .b_rdata_i(b_rdata_i),
        .add_op1_o(add_op1_o), .add_op2_o(add_op2_o), .add_valid_o(add_valid_o),
        .add_result_i(add_result_i), .add_valid_i(add_valid_i), .wr_en_o(wr_en_o),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
    );

    always #5 clk = ~clk;

    logic [11:0] mem_a [256];
    logic [11:0] mem_b [256];
    logic [11:0] dest  [256];
    logic [11:0] exp_d [256];
    logic [7:0]  vp = '0;
    logic [11:0] rp [8];
    int lat = 2;
    int cyc = 0;
    int checks = 0, errors = 0;
    int wr_n, done_n, rd_n, order_bad, op_bad, last_wr_cyc, done_cyc;

    function automatic logic [11:0] madd(input logic [11:0] x, input logic [11:0] y);
        logic [12:0] s;
        s = {1'b0, x} + {1'b0, y};
        return (s >= 13'd3329) ? 12'(s - 13'd3329) : s[11:0];
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en_o) begin
            a_rdata_i <= mem_a[rd_addr_o];
            b_rdata_i <= mem_b[rd_addr_o];
        end
        vp <= {vp[6:0], add_valid_o};
        rp[0] <= madd(add_op1_o, add_op2_o);
        for (int i = 1; i < 8; i++) rp[i] <= rp[i-1];
    end
    assign add_valid_i  = vp[lat-1];
    assign add_result_i = rp[lat-1];

    always @(negedge clk) begin
        if (wr_en_o) begin
            if (wr_addr_o != 8'(wr_n)) order_bad++;
            dest[wr_addr_o] = wr_data_o;
            wr_n++;
            last_wr_cyc = cyc;
        end
        if (rd_en_o) begin
            if (rd_addr_o != 8'(rd_n)) order_bad++;
            rd_n++;
        end
        if (!add_valid_o && (add_op1_o != 0 || add_op2_o != 0)) op_bad++;
        if (done_o) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        wr_n = 0; done_n = 0; rd_n = 0; order_bad = 0; op_bad = 0;
        last_wr_cyc = -100; done_cyc = -1;
        for (int i = 0; i < 256; i++) dest[i] = 12'hfff;
    endtask

    task automatic run(input string tag, input int lat_v, input bit inj, input bit b2b);
        bit seen;
        int bad;
        seen = 0;
        lat = lat_v;
        clear_mon();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        #1;
        chk({tag, "_first_rd"}, {busy_o, rd_en_o, rd_addr_o}, {1'b1, 1'b1, 8'd0});
        for (int k = 0; k < 1500 && !seen; k++) begin
            @(negedge clk);
            start_i = inj && rd_en_o && rd_addr_o == 8'd100;
            if (done_o) seen = 1;
        end
        start_i = 1'b0;
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        @(negedge clk);
        #1;
        if (!b2b) repeat (10) @(negedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < 256; i++) if (dest[i] !== exp_d[i]) bad++;
        chk({tag, "_writes"}, 64'(wr_n), 64'd256);
        chk({tag, "_dones"}, 64'(done_n), 64'd1);
        chk({tag, "_order"}, 64'(order_bad), 64'd0);
        chk({tag, "_opzero"}, 64'(op_bad), 64'd0);
        chk({tag, "_dest_bad"}, 64'(bad), 64'd0);
        chk({tag, "_dest1"}, 64'(dest[1]), 64'd2671);
        chk({tag, "_done_lat"}, 64'(done_cyc - last_wr_cyc), 64'd1);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 12'(i);
            mem_b[i] = 12'(3328 - i);
            exp_d[i] = 12'd3328;
        end
        mem_a[0] = 12'd3328; mem_b[0] = 12'd1;    exp_d[0] = 12'd0;
        mem_a[1] = 12'd3000; mem_b[1] = 12'd3000; exp_d[1] = 12'd2671;
        mem_a[2] = 12'd10;   mem_b[2] = 12'd20;   exp_d[2] = 12'd30;
        mem_a[3] = 12'd0;    mem_b[3] = 12'd0;    exp_d[3] = 12'd0;
        for (int i = 0; i < 8; i++) rp[i] = '0;
        clear_mon();

        repeat (2) @(negedge clk);
        #1;
        chk("rst_outs", {busy_o, done_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o,
                         add_valid_o, add_op1_o, add_op2_o}, 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("post_rst_outs", {busy_o, done_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o,
                              add_valid_o, add_op1_o, add_op2_o}, 64'd0);

        run("lat2", 2, 1'b0, 1'b0);
        run("lat1", 1, 1'b0, 1'b0);
        run("lat5", 5, 1'b0, 1'b0);
        run("midstart", 3, 1'b1, 1'b0);

        clear_mon();
        lat = 2;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < 500 && !(rd_en_o && rd_addr_o == 8'd50); k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        w0 = wr_n;
        chk("rst_mid_outs", {busy_o, rd_en_o, wr_en_o}, 64'd0);
        chk("rst_mid_inflight", 64'(add_valid_i), 64'd1);
        repeat (20) @(negedge clk);
        #1;
        chk("rst_mid_nodone", 64'(done_n), 64'd0);
        chk("rst_mid_nowr", 64'(wr_n), 64'(w0));
        run("after_rst", 2, 1'b0, 1'b0);

        run("b2b_a", 2, 1'b0, 1'b1);
        run("b2b_b", 2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
